// File: rtl/wb_bram_responder_if.sv
// Data-bus bundle between the memory-stage initiator and a block-RAM responder.
interface wb_bram_responder_if;
  logic        bus_cyc_i;
  logic        bus_stb_i;
  logic        bus_we_i;
  logic [31:0] bus_adr_i;
  logic [31:0] bus_dat_i;
  logic [3:0]  bus_sel_i;
  logic        bus_ack_o;
  logic [31:0] bus_dat_o;

  modport master (
    output bus_cyc_i, bus_stb_i, bus_we_i, bus_adr_i, bus_dat_i, bus_sel_i,
    input  bus_ack_o, bus_dat_o
  );

  modport slave (
    input  bus_cyc_i, bus_stb_i, bus_we_i, bus_adr_i, bus_dat_i, bus_sel_i,
    output bus_ack_o, bus_dat_o
  );
endinterface

// File: rtl/wb_bram_responder.sv
// Single-transfer bus responder in front of a word-organised block RAM.
// Each accepted request is acked after WAIT_STATES extra cycles.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for cyc&stb; request captured on the accepting edge
//   S_WAIT | burning wait states; counter reaching 0 moves to S_ACK
//   S_ACK  | ack driven (while cyc held); write commits on the closing edge
module wb_bram_responder #(
  parameter int AWIDTH      = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_bram_responder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam int         DEPTH   = 2 ** AWIDTH;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AWIDTH-1:0]   adr_q, adr_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         wdat_q, wdat_d;
  logic [31:0]         rdat_q, rdat_d;

  logic [31:0]         ram [0:DEPTH-1];
  logic                ram_we;
  logic                rd_en;
  logic [AWIDTH-1:0]   rd_idx;
  logic                ack;
  logic [AWIDTH-1:0]   req_idx;
  logic                unused_adr_bits;

  // Upper address bits alias the region (the decoder gates cyc); [1:0] are byte offsets.
  assign req_idx         = bus.bus_adr_i[AWIDTH+1:2];
  assign unused_adr_bits = ^{bus.bus_adr_i[31:AWIDTH+2], bus.bus_adr_i[1:0]};

  // Next-state, request capture and RAM port control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rd_en   = 1'b0;
    rd_idx  = adr_q;
    ram_we  = 1'b0;
    ack     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.bus_cyc_i && bus.bus_stb_i) begin
          adr_d  = req_idx;
          we_d   = bus.bus_we_i;
          sel_d  = bus.bus_sel_i;
          wdat_d = bus.bus_dat_i;
          if (WAIT_STATES == 0) begin
            // No captured copy exists yet, so the read uses the live address.
            state_d = S_ACK;
            rd_en   = !bus.bus_we_i;
            rd_idx  = req_idx;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!bus.bus_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          rd_en   = !we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (bus.bus_cyc_i) begin
          ack    = 1'b1;
          ram_we = we_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdat_d = rd_en ? ram[rd_idx] : rdat_q;
  end

  // Control and capture registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      wdat_q  <= 32'd0;
      rdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
    end
  end

  // Byte-lane RAM write; contents survive reset, but a write is dropped if reset lands on it.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_i && ram_we && sel_q[i]) begin
        ram[adr_q][8*i +: 8] <= wdat_q[8*i +: 8];
      end
    end
  end

  assign bus.bus_ack_o = ack;
  assign bus.bus_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_bram_responder.sv
// Bench for wb_bram_responder: three instances (0, 1 and 3 wait states) are driven
// with directed transfers; a cycle-numbered transaction model predicts ack/data.
module tb_wb_bram_responder;

  localparam int          NDUT          = 3;
  localparam int          WS_TAB [NDUT] = '{0, 1, 3};
  localparam logic [31:0] NOACK         = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc_a  [NDUT];
  logic        stb_a  [NDUT];
  logic        we_a   [NDUT];
  logic [31:0] adr_a  [NDUT];
  logic [31:0] wdat_a [NDUT];
  logic [3:0]  sel_a  [NDUT];
  logic        ack_a  [NDUT];
  logic [31:0] rdat_a [NDUT];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    wb_bram_responder_if bus ();
    assign bus.bus_cyc_i = cyc_a[k];
    assign bus.bus_stb_i = stb_a[k];
    assign bus.bus_we_i  = we_a[k];
    assign bus.bus_adr_i = adr_a[k];
    assign bus.bus_dat_i = wdat_a[k];
    assign bus.bus_sel_i = sel_a[k];
    assign ack_a[k]      = bus.bus_ack_o;
    assign rdat_a[k]     = bus.bus_dat_o;
    wb_bram_responder #(.AWIDTH(12), .WAIT_STATES(WS_TAB[k])) u_dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request accepted at edge m is acked in the cycle after
  // edge m+WS; reads sample memory on that edge, writes land on the next one.
  int          ecnt = 0;
  int          m;
  bit          mdl_live = 1'b0;
  bit          m_busy [NDUT];
  int          m_due  [NDUT];
  bit          m_we   [NDUT];
  logic [11:0] m_idx  [NDUT];
  logic [31:0] m_wd   [NDUT];
  logic [3:0]  m_sel  [NDUT];
  logic [31:0] m_dat  [NDUT];
  bit          m_dok  [NDUT];
  logic [31:0] m_mem  [NDUT][4096];
  logic [3:0]  m_vld  [NDUT][4096];

  always @(posedge clk) begin
    m = ecnt;
    ecnt++;
    if (!rst_n) mdl_live = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) begin
        m_busy[k] = 1'b0;
        m_dat[k]  = 32'd0;
        m_dok[k]  = 1'b1;
      end else if (m_busy[k]) begin
        if (!cyc_a[k]) begin
          m_busy[k] = 1'b0;
        end else if (m == m_due[k]) begin
          if (!m_we[k]) begin
            m_dat[k] = m_mem[k][m_idx[k]];
            m_dok[k] = (m_vld[k][m_idx[k]] == 4'hF);
          end
        end else if (m == m_due[k] + 1) begin
          if (m_we[k]) begin
            for (int i = 0; i < 4; i++)
              if (m_sel[k][i]) m_mem[k][m_idx[k]][8*i +: 8] = m_wd[k][8*i +: 8];
            m_vld[k][m_idx[k]] = m_vld[k][m_idx[k]] | m_sel[k];
          end
          m_busy[k] = 1'b0;
        end
      end else if (cyc_a[k] && stb_a[k]) begin
        m_busy[k] = 1'b1;
        m_due[k]  = m + WS_TAB[k];
        m_we[k]   = we_a[k];
        m_idx[k]  = adr_a[k][13:2];
        m_wd[k]   = wdat_a[k];
        m_sel[k]  = sel_a[k];
        if (WS_TAB[k] == 0 && !we_a[k]) begin
          m_dat[k] = m_mem[k][m_idx[k]];
          m_dok[k] = (m_vld[k][m_idx[k]] == 4'hF);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mdl_live) begin
      for (int k = 0; k < NDUT; k++) begin
        chk($sformatf("ack[%0d]", k), {31'd0, ack_a[k]},
            {31'd0, m_busy[k] && (ecnt - 1 == m_due[k]) && cyc_a[k]});
        if (m_dok[k]) chk($sformatf("dat_o[%0d]", k), rdat_a[k], m_dat[k]);
      end
    end
  end

  // One transfer on instance k. lat = cycles from stb to the observed ack, NOACK if none.
  task automatic xfer(input int k, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int abort_at, input bit restb,
                      input bit keep_cyc, output logic [31:0] lat);
    int  n;
    bit  got;
    @(posedge clk); #1;
    cyc_a[k] = 1'b1; stb_a[k] = 1'b1; we_a[k] = we;
    adr_a[k] = adr; wdat_a[k] = dat; sel_a[k] = sel;
    lat = NOACK;
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      stb_a[k] = restb && (n == 1);
      if (ack_a[k]) begin
        got = 1'b1;
        lat = 32'(n);
      end
      if (abort_at > 0 && n == abort_at) cyc_a[k] = 1'b0;
    end
    if (!keep_cyc && cyc_a[k]) begin
      @(posedge clk); #1;
      cyc_a[k] = 1'b0;
    end
  endtask

  logic [31:0] lat;

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      cyc_a[k] = 1'b0; stb_a[k] = 1'b0; we_a[k] = 1'b0;
      adr_a[k] = '0; wdat_a[k] = '0; sel_a[k] = '0;
      m_busy[k] = 1'b0; m_due[k] = 0; m_dat[k] = '0; m_dok[k] = 1'b0;
      for (int a = 0; a < 4096; a++) begin
        m_vld[k][a] = 4'd0;
        m_mem[k][a] = 32'd0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_ack[%0d]", k), {31'd0, ack_a[k]}, 32'd0);
      chk($sformatf("rst_dat[%0d]", k), rdat_a[k], 32'd0);
    end
    rst_n = 1'b1;

    // 1: one wait state, full write then read back
    xfer(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1'b0, lat); chk("t1_wr_lat", lat, 32'd2);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 1'b0, lat);
    chk("t1_rd_lat", lat, 32'd2);
    chk("t1_rd_dat", rdat_a[1], 32'hDEAD_BEEF);

    // 2: single byte lane over existing word
    xfer(1, 1'b1, 32'h11, 32'h00AA_0000, 4'b0100, 0, 1'b0, 1'b0, lat); chk("t2_wr_lat", lat, 32'd2);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 1'b0, lat);
    chk("t2_rd_dat", rdat_a[1], 32'hDEAA_BEEF);

    // 3: three wait states, write aborted mid-wait leaves old data
    xfer(2, 1'b1, 32'h20, 32'h0BAD_CAFE, 4'hF, 0, 1'b0, 1'b0, lat); chk("t3_wr_lat", lat, 32'd4);
    xfer(2, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 2, 1'b0, 1'b0, lat); chk("t3_abort_noack", lat, NOACK);
    xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 1'b0, lat);
    chk("t3_rd_lat", lat, 32'd4);
    chk("t3_rd_dat", rdat_a[2], 32'h0BAD_CAFE);

    // 4: back-to-back read then write, with a stray stb during the wait
    xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 1'b1, lat); chk("t4_rd_lat", lat, 32'd4);
    xfer(2, 1'b1, 32'h24, 32'h1, 4'hF, 0, 1'b1, 1'b0, lat); chk("t4_wr_lat", lat, 32'd4);
    xfer(2, 1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0, 1'b0, lat);
    chk("t4_rd_dat", rdat_a[2], 32'h0000_0001);

    // zero wait states, chained transfers with a partial write
    xfer(0, 1'b1, 32'h8, 32'h1122_3344, 4'hF, 0, 1'b0, 1'b1, lat); chk("z_wr_lat", lat, 32'd1);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0, 1'b1, lat);
    chk("z_rd_lat", lat, 32'd1);
    chk("z_rd_dat", rdat_a[0], 32'h1122_3344);
    xfer(0, 1'b1, 32'h9, 32'h0000_FF00, 4'b0010, 0, 1'b0, 1'b1, lat);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0, 1'b0, lat);
    chk("z_rd_dat2", rdat_a[0], 32'h1122_FF44);

    // cyc dropped inside the ack cycle discards the write
    xfer(1, 1'b1, 32'h40, 32'hA5A5_A5A5, 4'hF, 0, 1'b0, 1'b0, lat);
    xfer(1, 1'b1, 32'h40, 32'h5A5A_5A5A, 4'hF, 2, 1'b0, 1'b0, lat);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0, 1'b0, lat);
    chk("ackabort_rd_dat", rdat_a[1], 32'hA5A5_A5A5);

    // 5: reset during a pending write
    xfer(2, 1'b1, 32'h30, 32'h3333_3333, 4'hF, 0, 1'b0, 1'b0, lat);
    xfer(2, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, 1'b0, lat);
    @(posedge clk); #1;
    cyc_a[2] = 1'b1; stb_a[2] = 1'b1; we_a[2] = 1'b1;
    adr_a[2] = 32'h30; wdat_a[2] = 32'h4444_4444; sel_a[2] = 4'hF;
    @(posedge clk); #1;
    stb_a[2] = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_ack", {31'd0, ack_a[2]}, 32'd0);
    chk("t5_rst_dat", rdat_a[2], 32'd0);
    rst_n    = 1'b1;
    cyc_a[2] = 1'b0;
    xfer(2, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, 1'b0, lat);
    chk("t5_rd_30", rdat_a[2], 32'h3333_3333);
    xfer(2, 1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0, 1'b0, lat);
    chk("t5_rd_24", rdat_a[2], 32'h0000_0001);

    // 6: upper address bits alias onto the same word
    xfer(1, 1'b1, 32'h4010, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 1'b0, lat);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 1'b0, lat);
    chk("t6_alias_dat", rdat_a[1], 32'hCAFE_F00D);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
